// File: rtl/cache_repl_pkg.sv
// Shared definitions for the 8-way, 128-set replacement subsystem:
// geometry constants, the tag-lookup FSM state encoding and the
// one-hot way vector type used on the LRU update interface.
package cache_repl_pkg;

  localparam int SETS  = 128;
  localparam int WAYS  = 8;
  localparam int TAG_W = 12;
  localparam int IDX_W = $clog2(SETS);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOOKUP = 2'd1,
    VICTIM = 2'd2,
    UPDATE = 2'd3
  } state_t;

  typedef logic [WAYS-1:0]  way_oh_t;
  typedef logic [IDX_W-1:0] idx_t;
  typedef logic [TAG_W-1:0] tag_t;

  // True when a way vector has exactly one bit set.
  function automatic logic is_onehot(way_oh_t v);
    int cnt;
    cnt = 0;
    for (int i = 0; i < WAYS; i++) begin
      if (v[i]) cnt++;
    end
    return (cnt == 1);
  endfunction

endpackage

// File: rtl/way_onehot_pick.sv
// Lowest-set-bit one-hot picker. An all-zero request yields bit 0 so
// downstream logic always receives a legal one-hot way.
module way_onehot_pick #(
  parameter int W = 8
) (
  input  logic [W-1:0] req_i,
  output logic [W-1:0] gnt_o
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    gnt_o = '0;
    if (req_i == '0) begin
      gnt_o[0] = 1'b1;
    end else begin
      for (int i = W - 1; i >= 0; i--) begin
        if (req_i[i]) begin
          gnt_o    = '0;
          gnt_o[i] = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/cache_tag_lookup.sv
// Tag-lookup front end of the 8-way, 128-set replacement subsystem.
// Accepts one request at a time (ready only in IDLE), compares the tag
// against the valid ways of the selected set, installs the tag on a miss
// and emits a one-cycle LRU update strobe together with the response.
//
// Handshake: a request transfers on a rising edge where i_req_valid and
// o_req_ready are both high; o_resp_valid / o_lru_write_enable are
// single-cycle strobes with no back-pressure.
//
// Optional feature macro: CACHE_TAG_LOOKUP_INVALID_FIRST_EN
//   defined   - a miss fills the lowest-index invalid way first, and only
//               falls back to the LRU flag when the set is full.
//   undefined - a miss always fills the way named by the LRU flag.
module cache_tag_lookup
  import cache_repl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             i_req_valid,
  output logic             o_req_ready,
  input  logic [IDX_W-1:0] i_req_addr_7,
  input  logic [TAG_W-1:0] i_req_tag,
  input  logic [WAYS-1:0]  i_lru_flag_8,
  output logic [IDX_W-1:0] o_addr_7,
  output logic [WAYS-1:0]  o_hit_way_8,
  output logic             o_hit_sig,
  output logic             o_lru_write_enable,
  output logic             o_resp_valid,
  output logic             o_resp_hit,
  output logic [WAYS-1:0]  o_resp_way_8,
  output logic [1:0]       o_dbg_state
);

  state_t  state_q, state_d;
  idx_t    addr_q,  addr_d;
  tag_t    tag_q,   tag_d;
  way_oh_t way_q,   way_d;
  logic    hit_q,   hit_d;

  // Storage: tags are never reset, valid bits are.
  tag_t    tag_mem_q [SETS][WAYS];
  way_oh_t valid_q   [SETS];

  way_oh_t set_valid;
  way_oh_t match_raw;
  way_oh_t match_oh;
  way_oh_t flag_oh;
  way_oh_t fill_oh;
  logic    fill_we;

  // Compare the registered tag against every valid way of the registered set.
  always_comb begin
    set_valid = valid_q[addr_q];
    match_raw = '0;
    for (int w = 0; w < WAYS; w++) begin
      match_raw[w] = set_valid[w] && (tag_mem_q[addr_q][w] == tag_q);
    end
  end

  // Multiple matches should never occur; resolve them to the lowest way.
  way_onehot_pick #(.W(WAYS)) u_match_pick (
    .req_i (match_raw),
    .gnt_o (match_oh)
  );

  // Sanitise the LRU flag: non-one-hot -> lowest bit, zero -> way 0.
  way_onehot_pick #(.W(WAYS)) u_flag_pick (
    .req_i (i_lru_flag_8),
    .gnt_o (flag_oh)
  );

`ifdef CACHE_TAG_LOOKUP_INVALID_FIRST_EN
  way_oh_t invalid_oh;

  way_onehot_pick #(.W(WAYS)) u_invalid_pick (
    .req_i (~set_valid),
    .gnt_o (invalid_oh)
  );

  // Prefer an empty way; consult the LRU flag only when the set is full.
  always_comb begin
    fill_oh = (set_valid != '1) ? invalid_oh : flag_oh;
  end
`else
  // The LRU block alone decides the victim, even if empty ways exist.
  always_comb begin
    fill_oh = flag_oh;
  end
`endif

  // Next-state and datapath-capture logic for the lookup FSM.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    tag_d   = tag_q;
    way_d   = way_q;
    hit_d   = hit_q;
    fill_we = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (i_req_valid) begin
          addr_d  = i_req_addr_7;
          tag_d   = i_req_tag;
          state_d = LOOKUP;
        end
      end
      LOOKUP: begin
        if (match_raw != '0) begin
          way_d   = match_oh;
          hit_d   = 1'b1;
          state_d = UPDATE;
        end else begin
          state_d = VICTIM;
        end
      end
      VICTIM: begin
        fill_we = 1'b1;
        way_d   = fill_oh;
        hit_d   = 1'b0;
        state_d = UPDATE;
      end
      UPDATE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // FSM and captured request registers; reset drops any in-flight request.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      tag_q   <= '0;
      way_q   <= '0;
      hit_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      tag_q   <= tag_d;
      way_q   <= way_d;
      hit_q   <= hit_d;
    end
  end

  // Valid bits: cleared by reset, set for the filled way on a miss.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
      end
    end else if (fill_we) begin
      valid_q[addr_q] <= set_valid | fill_oh;
    end
  end

  // Tag install on a miss; a write in VICTIM commits even under reset,
  // but the matching valid bit is cleared so it is never hit.
  always_ff @(posedge clk) begin
    if (fill_we) begin
      for (int w = 0; w < WAYS; w++) begin
        if (fill_oh[w]) begin
          tag_mem_q[addr_q][w] <= tag_q;
        end
      end
    end
  end

  // Outputs are decoded from the state so reset yields all-zero except ready.
  always_comb begin
    o_req_ready        = (state_q == IDLE);
    o_addr_7           = (state_q != IDLE) ? addr_q : '0;
    o_lru_write_enable = (state_q == UPDATE);
    o_hit_way_8        = (state_q == UPDATE) ? way_q : '0;
    o_hit_sig          = (state_q == UPDATE) && hit_q;
    o_resp_valid       = (state_q == UPDATE);
    o_resp_hit         = (state_q == UPDATE) && hit_q;
    o_resp_way_8       = (state_q == UPDATE) ? way_q : '0;
    o_dbg_state        = state_q;
  end

endmodule

// File: doc/cache_tag_lookup.md
# cache_tag_lookup

- Tag-lookup front end of the 8-way, 128-set replacement subsystem.
- Accepts load/store requests, compares the request tag against the stored tags of the selected set, and installs the tag on a miss.
- On a miss, takes the victim way from the LRU block's one-hot flag.
- Generates the per-access LRU update (`hit_way_8`, `hit_sig`, `addr_7`, write-enable) that the LRU buffer consumes. It is the producer end of that update interface.

## Interface
- `SETS`, 128, number of sets; index width is clog2(SETS) = 7.
- `WAYS`, 8, associativity; one-hot way vectors are WAYS wide.
- `TAG_W`, 12, stored tag width.
- `clk`  input  1  single clock; all state updates on rising edge.
- `rst`  input  1  reset, synchronous, active-low.
- `i_req_valid`  input  1  request present.
- `o_req_ready`  output  1  block can accept a request (high only in IDLE).
- `i_req_addr_7`  input  7  set index.
- `i_req_tag`  input  TAG_W  request tag.
- `i_lru_flag_8`  input  8  one-hot victim way from the LRU block for set `o_addr_7`.
- `o_addr_7`  output  7  set index presented to the LRU block.
- `o_hit_way_8`  output  8  one-hot way to mark most-recently-used.
- `o_hit_sig`  output  1  1 = hit update, 0 = fill-after-miss update.
- `o_lru_write_enable`  output  1  one-cycle update strobe to the LRU block.
- `o_resp_valid`  output  1  one-cycle response strobe.
- `o_resp_hit`  output  1  response hit/miss.
- `o_resp_way_8`  output  8  one-hot way hit or filled.

## Operation
- **Storage:** tag array SETS×WAYS×TAG_W and valid array SETS×WAYS, both in flops.
- **IDLE:** `o_req_ready` = 1. When `i_req_valid` & `o_req_ready` are high, register addr/tag and go to LOOKUP.
- **LOOKUP:**
  - Drive `o_addr_7` = registered index.
  - Compare the tag on all valid ways of the set.
  - Any match → register the one-hot hit way and go to UPDATE with hit = 1.
  - No match → go to VICTIM.
  - Multiple matches cannot be produced by this block; if forced, the lowest index wins.
- **VICTIM:**
  - Select the fill way: the lowest-index invalid way (see Configuration); otherwise `i_lru_flag_8`, sampled this cycle.
  - Non-one-hot flag → lowest set bit. All-zero flag → way 0.
  - Write the tag, set valid, go to UPDATE with hit = 0.
- **UPDATE:**
  - `o_lru_write_enable` = 1.
  - `o_hit_way_8` = chosen way; `o_hit_sig` = hit; `o_addr_7` held.
  - `o_resp_valid` = 1, with `o_resp_hit` and `o_resp_way_8`.
  - Next state: IDLE.
- **Reset:** all valid bits cleared; tags left unreset.
- **Outputs at reset:** all outputs 0 except `o_req_ready` = 1; state = IDLE.
- **Reset mid-operation:** drop the request; no partial fill is kept. A tag write already committed in VICTIM stays, but its valid bit is cleared by reset.

## Timing
- Request accepted in cycle 0. The LRU strobe and response then coincide:
  - Hit: cycle 2.
  - Miss: cycle 3.
- `o_addr_7` is stable from the LOOKUP cycle through UPDATE. The LRU block must present a valid flag for that set by the VICTIM cycle (at least 1 cycle after the address is applied).
- `o_lru_write_enable` and `o_resp_valid` are single-cycle pulses, never back-to-back.
- Throughput is one request per 3 (hit) or 4 (miss) cycles, since ready is high only in IDLE.
- A fill in cycle N is visible to a lookup accepted in cycle N+1 or later.

## Configuration
- Macro: `CACHE_TAG_LOOKUP_INVALID_FIRST_EN`.
- Defined: on a miss, the lowest-index invalid way is filled before consulting `i_lru_flag_8`.
- Undefined: the fill way is always taken from `i_lru_flag_8`, even if invalid ways exist.

## Structure
- Package `cache_repl_pkg`:
  - SETS, WAYS, TAG_W, and index width constants.
  - State enum {IDLE, LOOKUP, VICTIM, UPDATE}.
  - One-hot way typedef.
- Sub-module `way_onehot_pick`: combinational lowest-set-bit one-hot picker (all-zero input → bit 0). Reused for the invalid-way select, flag sanitising and multi-match resolution.

## Test plan
- After reset, request set 5, tag 0x123 → miss. Response at cycle 3 with `o_hit_sig` = 0, way = 8'b0000_0001 (invalid-first), `o_addr_7` = 5.
- Repeat set 5, tag 0x123 → hit at cycle 2, `o_hit_way_8` = 8'b0000_0001, `o_lru_write_enable` pulse of width 1.
- Fill set 9 with 8 distinct tags, then a 9th tag with `i_lru_flag_8` = 8'b0001_0000 → fill way 4. The old way-4 tag now misses.
- Full set with `i_lru_flag_8` = 8'b0110_0000 → way 5 chosen; with 8'b0 → way 0.
- Without the macro, first miss on an empty set with flag 8'b1000_0000 → way 7 filled.
- Assert `rst` = 0 during VICTIM → next cycle state IDLE, no response, ready = 1; the same request afterwards misses.
